// File: rtl/csr_neighbor_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : csr_neighbor_fetcher
// Brief    : Reads a node's CSR row bounds, then streams its neighbour IDs
//            to a BFS processing unit under valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module csr_neighbor_fetcher #(
    parameter int NODE_BITS = 32,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] row_ptr_base_i,
    input  logic [ADDR_BITS-1:0] col_idx_base_i,
    input  logic                 fetch_en_i,
    input  logic [NODE_BITS-1:0] fetch_node_id_i,
    output logic [NODE_BITS-1:0] neighbor_id_o,
    output logic                 neighbor_valid_o,
    input  logic                 neighbor_ready_i,
    output logic                 fetch_done_o,
    output logic                 mem_rd_req_o,
    output logic [ADDR_BITS-1:0] mem_rd_addr_o,
    input  logic                 mem_rd_gnt_i,
    input  logic                 mem_rd_valid_i,
    input  logic [NODE_BITS-1:0] mem_rd_data_i,
    output logic                 busy_o,
    output logic                 csr_err_o,
    output logic [31:0]          edges_fetched_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_START = 3'd1,
        S_RD_END   = 3'd2,
        S_RD_EDGE  = 3'd3,
        S_EMIT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 wait_q, wait_d;   // 0: request phase, 1: waiting for data
    logic                 armed_q, armed_d;
    logic [NODE_BITS-1:0] node_q, node_d;
    logic [NODE_BITS-1:0] start_q, start_d;
    logic [NODE_BITS-1:0] end_q, end_d;
    logic [NODE_BITS-1:0] ptr_q, ptr_d;
    logic [NODE_BITS-1:0] nid_q, nid_d;
    logic                 err_q, err_d;
    logic [31:0]          edges_q, edges_d;
    logic [NODE_BITS-1:0] ptr_inc;

    assign ptr_inc = ptr_q + NODE_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            armed_q <= 1'b1;
            node_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            ptr_q   <= '0;
            nid_q   <= '0;
            err_q   <= 1'b0;
            edges_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            armed_q <= armed_d;
            node_q  <= node_d;
            start_q <= start_d;
            end_q   <= end_d;
            ptr_q   <= ptr_d;
            nid_q   <= nid_d;
            err_q   <= err_d;
            edges_q <= edges_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        armed_d       = armed_q | ~fetch_en_i;
        node_d        = node_q;
        start_d       = start_q;
        end_d         = end_q;
        ptr_d         = ptr_q;
        nid_d         = nid_q;
        err_d         = err_q;
        edges_d       = edges_q;
        mem_rd_req_o  = 1'b0;
        mem_rd_addr_o = '0;

        case (state_q)
            S_IDLE: begin
                if (fetch_en_i && armed_q) begin
                    node_d  = fetch_node_id_i;
                    wait_d  = 1'b0;
                    state_d = S_RD_START;
                end
            end
            S_RD_START: begin
                mem_rd_addr_o = row_ptr_base_i + ADDR_BITS'(node_q);
                mem_rd_req_o  = ~wait_q;
                if (!wait_q) begin
                    if (mem_rd_gnt_i) wait_d = 1'b1;
                end else if (mem_rd_valid_i) begin
                    start_d = mem_rd_data_i;
                    wait_d  = 1'b0;
                    state_d = S_RD_END;
                end
            end
            S_RD_END: begin
                mem_rd_addr_o = row_ptr_base_i + ADDR_BITS'(node_q) + ADDR_BITS'(1);
                mem_rd_req_o  = ~wait_q;
                if (!wait_q) begin
                    if (mem_rd_gnt_i) wait_d = 1'b1;
                end else if (mem_rd_valid_i) begin
                    end_d   = mem_rd_data_i;
                    ptr_d   = start_q;
                    wait_d  = 1'b0;
                    state_d = (mem_rd_data_i > start_q) ? S_RD_EDGE : S_DONE;
                    // A descending row is flagged and treated as an empty list.
                    if (mem_rd_data_i < start_q) err_d = 1'b1;
                end
            end
            S_RD_EDGE: begin
                mem_rd_addr_o = col_idx_base_i + ADDR_BITS'(ptr_q);
                mem_rd_req_o  = ~wait_q;
                if (!wait_q) begin
                    if (mem_rd_gnt_i) wait_d = 1'b1;
                end else if (mem_rd_valid_i) begin
                    nid_d   = mem_rd_data_i;
                    wait_d  = 1'b0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (neighbor_ready_i) begin
                    ptr_d   = ptr_inc;
                    edges_d = edges_q + 32'd1;
                    state_d = (ptr_inc == end_q) ? S_DONE : S_RD_EDGE;
                end
            end
            S_DONE: begin
                // Re-arm only once the request has been seen low.
                armed_d = ~fetch_en_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign neighbor_id_o    = nid_q;
    assign neighbor_valid_o = (state_q == S_EMIT);
    assign fetch_done_o     = (state_q == S_DONE);
    assign busy_o           = (state_q != S_IDLE);
    assign csr_err_o        = err_q;
    assign edges_fetched_o  = edges_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_neighbor_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_neighbor_fetcher
// Brief    : Directed bench for csr_neighbor_fetcher with a small memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_neighbor_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] row_ptr_base, col_idx_base;
    logic        fetch_en;
    logic [31:0] fetch_node_id;
    logic [31:0] neighbor_id;
    logic        neighbor_valid, neighbor_ready, fetch_done;
    logic        mem_rd_req, mem_rd_gnt, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic        busy, csr_err;
    logic [31:0] edges_fetched;
    logic        gnt_allow;

    logic [31:0] mem [64];
    int          lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pdata = '0;

    int tests = 0;
    int failed = 0;
    int overlap = 0;

    logic        v_log [40];
    logic        d_log [40];
    logic        b_log [40];
    logic        r_log [40];
    logic [31:0] id_log [40];
    logic [31:0] a_log [40];

    csr_neighbor_fetcher #(.NODE_BITS(32), .ADDR_BITS(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .row_ptr_base_i   (row_ptr_base),
        .col_idx_base_i   (col_idx_base),
        .fetch_en_i       (fetch_en),
        .fetch_node_id_i  (fetch_node_id),
        .neighbor_id_o    (neighbor_id),
        .neighbor_valid_o (neighbor_valid),
        .neighbor_ready_i (neighbor_ready),
        .fetch_done_o     (fetch_done),
        .mem_rd_req_o     (mem_rd_req),
        .mem_rd_addr_o    (mem_rd_addr),
        .mem_rd_gnt_i     (mem_rd_gnt),
        .mem_rd_valid_i   (mem_rd_valid),
        .mem_rd_data_i    (mem_rd_data),
        .busy_o           (busy),
        .csr_err_o        (csr_err),
        .edges_fetched_o  (edges_fetched)
    );

    always #5 clk = ~clk;

    // Graph memory: grant whenever allowed, data returns lat cycles later.
    assign mem_rd_gnt   = mem_rd_req & gnt_allow;
    assign mem_rd_valid = (pend_cnt == 1);
    assign mem_rd_data  = pdata;

    always @(posedge clk) begin
        if (mem_rd_req && mem_rd_gnt) begin
            pend_cnt <= lat;
            pdata    <= mem[mem_rd_addr[5:0]];
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Runs n cycles after the request cycle (cycle 0), logging outputs per cycle.
    task automatic capture(input int n, input bit hold, input int rlo, input int rhi,
                           input int glo, input int ghi);
        for (int c = 1; c <= n; c++) begin
            tick();
            if (!hold) fetch_en = 1'b0;
            neighbor_ready = !(c >= rlo && c < rhi);
            gnt_allow      = !(c >= glo && c < ghi);
            v_log[c]  = neighbor_valid;
            d_log[c]  = fetch_done;
            b_log[c]  = busy;
            r_log[c]  = mem_rd_req;
            id_log[c] = neighbor_id;
            a_log[c]  = mem_rd_addr;
            if (neighbor_valid && fetch_done) overlap++;
        end
    endtask

    function automatic int count_v(input int n);
        int k = 0;
        for (int c = 1; c <= n; c++) if (v_log[c]) k++;
        return k;
    endfunction

    function automatic int count_d(input int n);
        int k = 0;
        for (int c = 1; c <= n; c++) if (d_log[c]) k++;
        return k;
    endfunction

    task automatic start_fetch(input logic [31:0] node);
        fetch_node_id = node;
        fetch_en      = 1'b1;
        neighbor_ready = 1'b1;
        gnt_allow     = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        // row_ptr at 16: [0,3,3,5,3]; col_idx at 32: [7,9,11,2,4]
        mem[16] = 0; mem[17] = 3; mem[18] = 3; mem[19] = 5; mem[20] = 3;
        mem[32] = 7; mem[33] = 9; mem[34] = 11; mem[35] = 2; mem[36] = 4;
        row_ptr_base   = 32'd16;
        col_idx_base   = 32'd32;
        fetch_en       = 1'b0;
        fetch_node_id  = '0;
        neighbor_ready = 1'b1;
        gnt_allow      = 1'b1;
        rst            = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_valid", neighbor_valid, 0);
        chk("rst_done",  fetch_done, 0);
        chk("rst_req",   mem_rd_req, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_err",   csr_err, 0);
        chk("rst_edges", edges_fetched, 0);
        chk("rst_id",    neighbor_id, 0);
        chk("rst_addr",  mem_rd_addr, 0);

        // Node 0: neighbours 7, 9, 11 at cycles 7, 10, 13; done at 14.
        start_fetch(0);
        capture(16, 1'b0, 0, 0, 0, 0);
        chk("t1_busy1",  b_log[1], 1);
        chk("t1_req1",   r_log[1], 1);
        chk("t1_addr1",  a_log[1], 16);
        chk("t1_req3",   r_log[3], 1);
        chk("t1_addr3",  a_log[3], 17);
        chk("t1_addr5",  a_log[5], 32);
        chk("t1_v6",     v_log[6], 0);
        chk("t1_v7",     v_log[7], 1);
        chk("t1_id7",    id_log[7], 7);
        chk("t1_v10",    v_log[10], 1);
        chk("t1_id10",   id_log[10], 9);
        chk("t1_v13",    v_log[13], 1);
        chk("t1_id13",   id_log[13], 11);
        chk("t1_d14",    d_log[14], 1);
        chk("t1_vcount", count_v(16), 3);
        chk("t1_dcount", count_d(16), 1);
        chk("t1_busy14", b_log[14], 1);
        chk("t1_busy15", b_log[15], 0);
        chk("t1_edges",  edges_fetched, 3);

        // Node 1 (degree 0) with grant stalled in cycles 1-2: done at 5+2.
        start_fetch(1);
        gnt_allow = 1'b1;
        capture(10, 1'b0, 0, 0, 1, 3);
        chk("t2_req2",   r_log[2], 1);
        chk("t2_addr2",  a_log[2], 17);
        chk("t2_d5",     d_log[5], 0);
        chk("t2_d7",     d_log[7], 1);
        chk("t2_vcount", count_v(10), 0);
        chk("t2_err",    csr_err, 0);

        // Node 2 with ready low on cycles 7-10: id 2 held five cycles.
        start_fetch(2);
        capture(18, 1'b0, 7, 11, 0, 0);
        begin
            int k = 0;
            for (int c = 1; c <= 18; c++) if (v_log[c] && id_log[c] == 2) k++;
            chk("t3_hold2", k, 5);
        end
        chk("t3_req10",  r_log[10], 0);
        chk("t3_v14",    v_log[14], 1);
        chk("t3_id14",   id_log[14], 4);
        chk("t3_d15",    d_log[15], 1);
        chk("t3_vcount", count_v(18), 6);
        chk("t3_edges",  edges_fetched, 5);

        // Level-held request fetches once; a one-cycle drop re-arms.
        start_fetch(0);
        capture(30, 1'b1, 0, 0, 0, 0);
        chk("t4_dcount", count_d(30), 1);
        chk("t4_d14",    d_log[14], 1);
        chk("t4_busy29", b_log[29], 0);
        fetch_en = 1'b0;
        tick();
        start_fetch(0);
        capture(16, 1'b1, 0, 0, 0, 0);
        chk("t4b_v7",    v_log[7], 1);
        chk("t4b_id7",   id_log[7], 7);
        chk("t4b_d14",   d_log[14], 1);
        chk("t4b_edges", edges_fetched, 11);
        fetch_en = 1'b0;
        tick();

        // Node 3: row_ptr[3]=5 > row_ptr[4]=3 raises csr_err.
        start_fetch(3);
        capture(8, 1'b0, 0, 0, 0, 0);
        chk("t5_d5",     d_log[5], 1);
        chk("t5_vcount", count_v(8), 0);
        chk("t5_err",    csr_err, 1);
        start_fetch(1);
        capture(8, 1'b0, 0, 0, 0, 0);
        chk("t5_sticky", csr_err, 1);
        chk("t5_edges",  edges_fetched, 11);

        // Reset in RD_EDGE wait phase with L=2; response lands in cycle 9.
        lat = 2;
        start_fetch(0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            fetch_en = 1'b0;
            if (c == 7) chk("t6_req7", {31'd0, mem_rd_req}, 1);
            if (c == 7) chk("t6_addr7", mem_rd_addr, 32);
        end
        chk("t6_wait_req",  mem_rd_req, 0);
        chk("t6_wait_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid",  neighbor_valid, 0);
        chk("t6_done",   fetch_done, 0);
        chk("t6_req",    mem_rd_req, 0);
        chk("t6_busy",   busy, 0);
        chk("t6_err",    csr_err, 0);
        chk("t6_edges",  edges_fetched, 0);
        chk("t6_id",     neighbor_id, 0);
        chk("t6_addr",   mem_rd_addr, 0);
        tick();
        chk("t6_busy_after",  busy, 0);
        chk("t6_valid_after", neighbor_valid, 0);
        lat = 1;

        start_fetch(2);
        capture(14, 1'b0, 0, 0, 0, 0);
        chk("t7_v7",     v_log[7], 1);
        chk("t7_id7",    id_log[7], 2);
        chk("t7_v10",    v_log[10], 1);
        chk("t7_id10",   id_log[10], 4);
        chk("t7_d11",    d_log[11], 1);
        chk("t7_vcount", count_v(14), 2);
        chk("t7_edges",  edges_fetched, 2);
        chk("overlap",   overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
